// File: rtl/biquad_cfg_pkg.sv
// Shared types and constants for the biquad cascade config sequencer.
package biquad_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_SKIP,
    S_DONE
  } cfg_state_t;

  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A0 = 3;
  localparam int A1 = 4;
  localparam int A2 = 5;
  localparam int COEF_SLOTS = 6;

  // Unity gain in Qq format, saturated one LSB below 1.0
  function automatic logic [31:0] coef_one(input int q);
    logic [63:0] one;
    one = (64'd1 << q) - 64'd1;
    return one[31:0];
  endfunction

endpackage

// File: rtl/biquad_cascade_config_sequencer_decii_strobe_gen.sv
// Decimated-rate run strobe; held at phase zero while frozen.
module decii_strobe_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic [W-1:0] div,
  output logic         strobe
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (freeze || cnt >= div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign strobe = !rst && !freeze && (cnt == div);

endmodule

// File: rtl/biquad_cascade_config_sequencer.sv
// Stages biquad coefficient sets and loads them stage by stage on commit,
// freezing the decimated run strobe while a load is in flight.
module biquad_cascade_config_sequencer
  import biquad_cfg_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int BASE_ADDRESS = 1000,
  parameter int HOLD_CYCLES  = 4,
  parameter int COEF_Q       = 28,
  parameter int DECII_WIDTH  = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cfg_wr_en,
  input  logic [2:0]             cfg_wr_stage,
  input  logic [2:0]             cfg_wr_slot,
  input  logic [31:0]            cfg_wr_data,
  input  logic                   commit,
  input  logic [NUM_STAGES-1:0]  commit_mask,
  input  logic [DECII_WIDTH-1:0] decii_div,
  output logic [31:0]            config_addr,
  output logic [511:0]           config_data,
  output logic                   axis_decii_clk,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_STAGES-1:0]  stage_loaded,
  output logic                   err
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef logic [COEF_SLOTS-1:0][31:0] coef_set_t;

  cfg_state_t            state, state_d;
  logic [IW-1:0]         idx, idx_d;
  logic [HW-1:0]         hcnt, hcnt_d;
  logic [NUM_STAGES-1:0] mask_q, mask_sh;
  coef_set_t             stg [NUM_STAGES];
  logic [511:0]          cur_data, data_q;
  logic                  idle, last, freeze;
  logic                  stage_ok, slot_ok, wr_ok;

  assign idle     = (state == S_IDLE);
  assign last     = (idx == IW'(NUM_STAGES - 1));
  assign mask_sh  = mask_q >> (idx + IW'(1));
  assign stage_ok = {29'd0, cfg_wr_stage} < 32'(NUM_STAGES);
  assign slot_ok  = cfg_wr_slot < 3'(COEF_SLOTS);
  assign wr_ok    = idle && cfg_wr_en && !commit && stage_ok && slot_ok;
  assign cur_data = {320'd0, stg[idx]};

  always_comb begin
    state_d = state;
    idx_d   = idx;
    hcnt_d  = hcnt;
    unique case (state)
      S_IDLE: begin
        if (commit) begin
          idx_d   = '0;
          hcnt_d  = '0;
          state_d = commit_mask[0] ? S_DRIVE : S_SKIP;
        end
      end
      S_DRIVE: begin
        if (hcnt == HW'(HOLD_CYCLES - 1)) state_d = S_GAP;
        else hcnt_d = hcnt + HW'(1);
      end
      S_GAP, S_SKIP: begin
        if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx + IW'(1);
          hcnt_d  = '0;
          state_d = mask_sh[0] ? S_DRIVE : S_SKIP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= S_IDLE;
      idx    <= '0;
      hcnt   <= '0;
      mask_q <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      hcnt  <= hcnt_d;
      if (idle && commit) mask_q <= commit_mask;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stage_loaded <= '0;
      err          <= 1'b0;
      data_q       <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stg[s]     <= '0;
        stg[s][B0] <= coef_one(COEF_Q);
      end
    end else begin
      // A commit clears err unless it collides with a write
      if (idle) begin
        if (commit) err <= cfg_wr_en;
      end else if (commit || cfg_wr_en) begin
        err <= 1'b1;
      end
      if (state == S_GAP) stage_loaded[idx] <= 1'b1;
      if (state == S_DRIVE) data_q <= cur_data;
      if (wr_ok) stg[IW'(cfg_wr_stage)][cfg_wr_slot] <= cfg_wr_data;
    end
  end

  assign config_addr = (state == S_DRIVE) ?
                       32'(BASE_ADDRESS) + 32'(idx) : '0;
  assign config_data = (state == S_DRIVE) ? cur_data : data_q;
  assign busy        = (state == S_DRIVE) || (state == S_GAP) ||
                       (state == S_SKIP);
  assign done        = (state == S_DONE);
  assign freeze      = !idle;

  decii_strobe_gen #(
    .W(DECII_WIDTH)
  ) u_decii (
    .clk   (aclk),
    .rst   (areset),
    .freeze(freeze),
    .div   (decii_div),
    .strobe(axis_decii_clk)
  );

endmodule

// File: tb/tb_biquad_cascade_config_sequencer.sv
// Directed bench for the biquad cascade config sequencer.
module tb_biquad_cascade_config_sequencer;
  import biquad_cfg_pkg::*;

  localparam int NS   = 4;
  localparam int HOLD = 4;
  localparam int BASE = 1000;
  localparam logic [511:0] DEF = 512'h0FFFFFFF;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_wr_en;
  logic [2:0]    cfg_wr_stage;
  logic [2:0]    cfg_wr_slot;
  logic [31:0]   cfg_wr_data;
  logic          commit;
  logic [NS-1:0] commit_mask;
  logic [15:0]   decii_div;
  logic [31:0]   config_addr;
  logic [511:0]  config_data;
  logic          axis_decii_clk;
  logic          busy;
  logic          done;
  logic [NS-1:0] stage_loaded;
  logic          err;

  int checks = 0;
  int fails  = 0;
  logic [511:0] cap [NS];

  biquad_cascade_config_sequencer #(
    .NUM_STAGES(NS), .BASE_ADDRESS(BASE), .HOLD_CYCLES(HOLD),
    .COEF_Q(28), .DECII_WIDTH(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_stage(cfg_wr_stage),
    .cfg_wr_slot(cfg_wr_slot), .cfg_wr_data(cfg_wr_data),
    .commit(commit), .commit_mask(commit_mask),
    .decii_div(decii_div),
    .config_addr(config_addr), .config_data(config_data),
    .axis_decii_clk(axis_decii_clk), .busy(busy), .done(done),
    .stage_loaded(stage_loaded), .err(err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input int st, input int sl, input logic [31:0] d);
    cfg_wr_stage = 3'(st);
    cfg_wr_slot  = 3'(sl);
    cfg_wr_data  = d;
    cfg_wr_en    = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  // Commit in the current cycle, then follow the load cycle by cycle.
  task automatic walk(input logic [3:0] mask, input int exp_len,
                      input int inj_c, input int inj_w,
                      output int strobes, output int busy_n);
    int q[$];
    int exp_a;
    int prev;
    for (int i = 0; i < NS; i++) begin
      if (mask[i]) begin
        repeat (HOLD) q.push_back(BASE + i);
        q.push_back(0);
      end else begin
        q.push_back(0);
      end
    end
    strobes = 0;
    busy_n  = 0;
    prev    = 0;
    commit = 1'b1;
    commit_mask = mask;
    tick();
    commit = 1'b0;
    for (int k = 1; k <= q.size() + 1; k++) begin
      commit    = (k == inj_c);
      cfg_wr_en = (k == inj_w);
      @(negedge aclk);
      exp_a = (k <= q.size()) ? q[k-1] : 0;
      checks++;
      if (config_addr !== 32'(exp_a)) begin
        fails++;
        $display("FAIL addr k=%0d: got %0d expected %0d", k, config_addr, exp_a);
      end
      checks++;
      if (busy !== (k <= q.size())) begin
        fails++;
        $display("FAIL busy k=%0d: got %b", k, busy);
      end
      checks++;
      if (done !== (k == q.size() + 1)) begin
        fails++;
        $display("FAIL done k=%0d: got %b", k, done);
      end
      if (busy === 1'b1) busy_n++;
      if (axis_decii_clk === 1'b1) strobes++;
      if (exp_a != 0) begin
        cap[exp_a - BASE] = config_data;
      end else if (prev != 0) begin
        checks++;
        if (config_data !== cap[prev - BASE]) begin
          fails++;
          $display("FAIL gap_hold k=%0d: got %h expected %h", k, config_data, cap[prev - BASE]);
        end
      end
      prev = exp_a;
      tick();
    end
    commit    = 1'b0;
    cfg_wr_en = 1'b0;
    checks++;
    if (busy_n != exp_len) begin
      fails++;
      $display("FAIL load_len: got %0d expected %0d", busy_n, exp_len);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    cfg_wr_en = 1'b0;
    cfg_wr_stage = '0;
    cfg_wr_slot = '0;
    cfg_wr_data = '0;
    commit = 1'b0;
    commit_mask = '0;
    decii_div = '0;
    repeat (2) tick();
    @(negedge aclk);
    checks++;
    if ({config_addr, busy, done, stage_loaded, err, axis_decii_clk} !== '0) begin
      fails++;
      $display("FAIL reset_outs: addr=%0d busy=%b done=%b loaded=%b err=%b strobe=%b",
               config_addr, busy, done, stage_loaded, err, axis_decii_clk);
    end
    checks++;
    if (config_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", config_data);
    end
    areset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      checks++;
      if (axis_decii_clk !== 1'b1) begin
        fails++;
        $display("FAIL div0_strobe: got %b expected 1", axis_decii_clk);
      end
      tick();
    end
  endtask

  task automatic test_single_stage();
    int s, b;
    walk(4'b0001, 8, 0, 0, s, b);
    checks++;
    if (cap[0] !== DEF) begin
      fails++;
      $display("FAIL default_coef: got %h expected %h", cap[0], DEF);
    end
    checks++;
    if (stage_loaded !== 4'b0001 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_status: loaded=%b err=%b expected 0001/0", stage_loaded, err);
    end
  endtask

  task automatic test_two_stage();
    int s, b;
    logic [511:0] exp2;
    exp2 = DEF | (512'hF0000000 << 128);
    wr(2, A1, 32'hF0000000);
    walk(4'b0101, 12, 0, 0, s, b);
    checks++;
    if (cap[2] !== exp2) begin
      fails++;
      $display("FAIL stage2_data: got %h expected %h", cap[2], exp2);
    end
    checks++;
    if (stage_loaded !== 4'b0101) begin
      fails++;
      $display("FAIL two_loaded: got %b expected 0101", stage_loaded);
    end
  endtask

  task automatic test_decimation();
    int pos[$];
    int s, b, first;
    bit found;
    decii_div = 16'd3;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (axis_decii_clk === 1'b1) pos.push_back(i);
      tick();
    end
    checks++;
    if (pos.size() != 4) begin
      fails++;
      $display("FAIL strobe_count: got %0d expected 4", pos.size());
    end
    for (int i = 1; i < pos.size(); i++) begin
      checks++;
      if (pos[i] - pos[i-1] != 4) begin
        fails++;
        $display("FAIL strobe_period: got %0d expected 4", pos[i] - pos[i-1]);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge aclk);
      if (axis_decii_clk === 1'b1) found = 1'b1;
      tick();
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL strobe_seen: got none expected one within 8 cycles");
    end
    tick();
    walk(4'b0000, 4, 0, 0, s, b);
    checks++;
    if (s != 0) begin
      fails++;
      $display("FAIL strobe_frozen: got %0d strobes expected 0", s);
    end
    first = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge aclk);
      if (axis_decii_clk === 1'b1 && first == 0) first = n;
      tick();
    end
    checks++;
    if (first != 4) begin
      fails++;
      $display("FAIL strobe_after_done: got %0d expected 4", first);
    end
  endtask

  task automatic test_err();
    int s, b;
    cfg_wr_stage = 3'd1;
    cfg_wr_slot  = 3'(B0);
    cfg_wr_data  = 32'h12345678;
    walk(4'b0010, 8, 2, 3, s, b);
    checks++;
    if (err !== 1'b1 || stage_loaded !== 4'b0111) begin
      fails++;
      $display("FAIL busy_err: err=%b loaded=%b expected 1/0111", err, stage_loaded);
    end
    walk(4'b0010, 8, 0, 0, s, b);
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    checks++;
    if (cap[1] !== DEF) begin
      fails++;
      $display("FAIL busy_write_dropped: got %h expected %h", cap[1], DEF);
    end
    cfg_wr_en = 1'b1;
    walk(4'b0010, 8, 0, 0, s, b);
    checks++;
    if (err !== 1'b1 || cap[1] !== DEF) begin
      fails++;
      $display("FAIL commit_priority: err=%b data=%h expected 1/%h", err, cap[1], DEF);
    end
  endtask

  task automatic test_async_reset();
    int s, b;
    wr(0, B0, 32'h11111111);
    commit = 1'b1;
    commit_mask = 4'b1111;
    tick();
    commit = 1'b0;
    repeat (11) tick();
    @(negedge aclk);
    checks++;
    if (config_addr !== 32'd1002 || stage_loaded !== 4'b0111) begin
      fails++;
      $display("FAIL pre_reset: addr=%0d loaded=%b expected 1002/0111", config_addr, stage_loaded);
    end
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (config_addr !== '0 || busy !== 1'b0 || stage_loaded !== '0 || config_data !== '0) begin
      fails++;
      $display("FAIL async_reset: addr=%0d busy=%b loaded=%b", config_addr, busy, stage_loaded);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    walk(4'b0001, 8, 0, 0, s, b);
    checks++;
    if (cap[0] !== DEF) begin
      fails++;
      $display("FAIL b0_revert: got %h expected %h", cap[0], DEF);
    end
  endtask

  task automatic test_out_of_range();
    int s, b;
    wr(5, B0, 32'hDEADBEEF);
    wr(1, 7, 32'hDEADBEEF);
    wr(3, 6, 32'hDEADBEEF);
    walk(4'b1111, 20, 0, 0, s, b);
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (cap[i] !== DEF) begin
        fails++;
        $display("FAIL range_ignore st%0d: got %h expected %h", i, cap[i], DEF);
      end
    end
    checks++;
    if (stage_loaded !== 4'b1111 || err !== 1'b0) begin
      fails++;
      $display("FAIL all_loaded: loaded=%b err=%b expected 1111/0", stage_loaded, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_two_stage();
    test_decimation();
    test_err();
    test_async_reset();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
